// File: rtl/div70x35_seq_if.sv
// Request/result bundle for the 70/35 sequential divider.
// The master drives operands and START; the slave returns the quotient, remainder and status.
interface div70x35_seq_if #(parameter int W = 35);
  logic           start;
  logic [2*W-1:0] prod_in;
  logic [W-1:0]   b_in;
  logic [W-1:0]   q_out;
  logic [W-1:0]   r_out;
  logic           busy;
  logic           done;
  logic           ovf;

  modport master (
    output start, prod_in, b_in,
    input  q_out, r_out, busy, done, ovf
  );

  modport slave (
    input  start, prod_in, b_in,
    output q_out, r_out, busy, done, ovf
  );
endinterface

// File: rtl/div70x35_seq.sv
// Radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Latency W cycles from the accepting edge to DONE (1 cycle on early overflow); START is ignored while busy, not queued.
// Optional macro DIV_OVF_CHECK_EN enables the load-time overflow check and the OVF output.
module div70x35_seq #(
  parameter int W = 35
) (
  input  logic          clk,
  input  logic          rst,
  div70x35_seq_if.slave dif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        state;
  logic [W-1:0]  rem;
  logic [W-1:0]  shreg;
  logic [W-1:0]  div;
  logic [W-1:0]  qreg;
  logic [W-1:0]  q_out_r;
  logic [W-1:0]  r_out_r;
  logic [CW-1:0] cnt;
  logic          busy_r;
  logic          done_r;
  logic          ovf_r;
`ifdef DIV_OVF_CHECK_EN
  logic          ovf_pend;
`endif

  // The partial remainder stays below the divisor, so only its low W bits feed the next shift;
  // the shifted-out MSB survives as t[W] for the compare.
  logic [W:0]   t;
  logic [W-1:0] t_sub;
  logic         qbit;

  always_comb begin
    t     = {rem, shreg[W-1]};
    qbit  = (t >= {1'b0, div});
    t_sub = t[W-1:0] - div;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rem     <= '0;
      shreg   <= '0;
      div     <= '0;
      qreg    <= '0;
      q_out_r <= '0;
      r_out_r <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
`ifdef DIV_OVF_CHECK_EN
      ovf_pend <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (dif.start) begin
            rem    <= dif.prod_in[2*W-1:W];
            shreg  <= dif.prod_in[W-1:0];
            div    <= dif.b_in;
            qreg   <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            state  <= S_CALC;
`ifdef DIV_OVF_CHECK_EN
            ovf_pend <= (dif.prod_in[2*W-1:W] >= dif.b_in);
`endif
          end
        end

        S_CALC: begin
`ifdef DIV_OVF_CHECK_EN
          // Quotient cannot fit in W bits: saturate and skip the iterations.
          if (ovf_pend) begin
            ovf_pend <= 1'b0;
            q_out_r  <= '1;
            r_out_r  <= '0;
            ovf_r    <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end else
`endif
          begin
            shreg <= shreg << 1;
            rem   <= qbit ? t_sub : t[W-1:0];
            qreg  <= {qreg[W-2:0], qbit};
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
              q_out_r <= {qreg[W-2:0], qbit};
              r_out_r <= qbit ? t_sub : t[W-1:0];
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign dif.q_out = q_out_r;
  assign dif.r_out = r_out_r;
  assign dif.busy  = busy_r;
  assign dif.done  = done_r;
  assign dif.ovf   = ovf_r;

endmodule

// File: doc/div70x35_seq.md
# div70x35_seq

Iterative radix-2 restoring divider. It is the inverse of the 35x35 parallel pipelined multiplier: it takes a 70-bit product and one 35-bit factor, and returns the other factor plus a remainder. It sits beside the multiplier in the 32-bit processor datapath and serves DIV/MOD operations and multiplier self-check loops. It produces one quotient bit per clock under a START/BUSY/DONE handshake.

## Interface
- W, 35: operand width; dividend is 2W bits; divisor, quotient and remainder are W bits.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  request; sampled only in IDLE.
- PROD_IN  in  2W  dividend; captured on the accepting edge.
- B_IN  in  W  divisor; captured on the accepting edge.
- Q_OUT  out  W  quotient; registered; reset 0.
- R_OUT  out  W  remainder; registered; reset 0.
- BUSY  out  1  high in CALC; reset 0.
- DONE  out  1  one-cycle completion pulse; reset 0.
- OVF  out  1  quotient does not fit in W bits (includes B_IN==0); valid with DONE; reset 0.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE and clears all outputs, counter and datapath registers.
- IDLE to CALC on START=1:
  - Load rem = {1'b0, PROD_IN[2W-1:W]}, shreg = PROD_IN[W-1:0], div = B_IN, cnt = 0.
  - Clear DONE and OVF.
- CALC, each edge:
  - t = {rem[W-1:0], shreg[W-1]}; shreg <<= 1.
  - If t >= {1'b0,div}: rem = t - div and the quotient bit is 1; otherwise rem = t and the bit is 0.
  - The quotient bit shifts into the LSB of the quotient register.
  - cnt increments; the edge with cnt==W-1 moves to DONE and writes Q_OUT/R_OUT.
- DONE: DONE=1 for exactly one cycle, then IDLE unconditionally.
- Q_OUT/R_OUT/OVF hold until the next accepted START. They are not cleared on return to IDLE.
- START while in CALC or DONE is ignored. It is not queued.
- PROD_IN/B_IN changes after the accepting edge have no effect.
- Arithmetic is unsigned.
  - Comparison uses a W+1-bit rem so the shifted-out MSB is not lost.
  - When no overflow occurs, the result satisfies PROD_IN == Q_OUT*B_IN + R_OUT with R_OUT < B_IN.
- RST in any state, including mid-CALC, aborts the operation. The next cycle is IDLE with all outputs 0, and the partial result is discarded.

## Timing
- Accepting edge is t0 (IDLE, START=1).
- BUSY is high from t0 through the edge at t0+W, and low after t0+W.
- Without overflow, DONE=1 and Q_OUT/R_OUT are valid in the cycle following edge t0+W, so latency is W=35 cycles.
- With overflow (DIV_OVF_CHECK_EN defined), DONE=1 and OVF=1 in the cycle following edge t0+1, so latency is 1 cycle.
- The earliest next accepted START is the edge at t0+W+2 (t0+3 for overflow). Back-to-back throughput is one result per W+2 cycles.
- An edge in IDLE with START=1 and RST=1 is a reset; RST wins.

## Configuration
- DIV_OVF_CHECK_EN defined:
  - On the accepting edge, overflow is PROD_IN[2W-1:W] >= B_IN (this covers B_IN==0).
  - On overflow, go IDLE to CALC for one edge, then to DONE with Q_OUT = all ones, R_OUT = 0, OVF = 1. The W iterations are skipped.
- DIV_OVF_CHECK_EN undefined:
  - No compare at load; OVF is held at 0.
  - Every request runs the full W iterations.
  - On overflow inputs Q_OUT/R_OUT are unspecified but deterministic. Callers guarantee PROD_IN[2W-1:W] < B_IN.

## Test plan
- PROD_IN=1000, B_IN=7, START at t0 -> BUSY for 35 cycles, DONE pulse after edge t0+35, Q_OUT=142, R_OUT=6, OVF=0.
- PROD_IN=(2^35-1)^2, B_IN=2^35-1 -> Q_OUT=34359738367, R_OUT=0. Also feed each pair through mult35x35_parallel_pipe and back, and check Q_OUT equals A_IN.
- With the macro on: B_IN=0, PROD_IN=12345 -> DONE after edge t0+1, OVF=1, Q_OUT=34359738367, R_OUT=0. Then PROD_IN=5*2^35, B_IN=5 -> OVF=1.
- START held high for 40 cycles while BUSY with different operands -> only the first request is computed. A second result follows only after DONE and an IDLE cycle.
- RST pulsed 10 edges into CALC -> next cycle is IDLE with BUSY=0, DONE=0, Q_OUT=0, R_OUT=0. A fresh request of 1000/7 then returns 142/6.
- Random sweep of 10k pairs with PROD_IN[69:35] < B_IN -> Q_OUT*B_IN+R_OUT==PROD_IN and R_OUT<B_IN every time. A single global fail flag is checked at the end.
